// File: rtl/max_stream_collector_pkg.sv
// Shared types and helpers for the max-of-N stream collector.
// The optional flush port is controlled by the MAX_FLUSH_EN macro, which is used in the top module.
package max_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int GROUP_N_DEF = 3;

  // COLLECT: beats flow freely. STALL: a group-closing beat waits for downstream.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  // Width of a beat index within a group. It is kept at least 1 bit wide.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_stream_collector_cmp.sv
// Unsigned two-input maximum.
// When the inputs are equal, the newer sample b is selected, so sel_b = (b >= a).
module max_cmp #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] max_val,
  output logic              sel_b
);

  // Pick the larger value; ties go to b.
  always_comb begin
    sel_b   = (b >= a);
    max_val = sel_b ? b : a;
  end

endmodule

// File: rtl/max_stream_collector.sv
// max_stream_collector: groups GROUP_N consecutive valid/ready beats and emits
// one registered (max, index) result per group. Back-pressure from the result
// port only blocks the beat that would close the next group.
// Optional feature: define MAX_FLUSH_EN to add a flush port that closes a
// partial group early.
module max_stream_collector
  import max_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int GROUP_N = GROUP_N_DEF,
  localparam int IDX_W   = idx_w(GROUP_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
`ifdef MAX_FLUSH_EN
  input  logic              flush,
`endif
  output logic [IDX_W-1:0]  out_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(GROUP_N - 1);

  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] run_max;
  logic [IDX_W-1:0]  run_idx;
  state_t            state;

  logic              at_last;
  logic              close_pos;
  logic              out_stall;
  logic              beat;
  logic              close;
  logic [DATA_W-1:0] cmp_max;
  logic              cmp_sel_b;
  logic [DATA_W-1:0] nxt_max;
  logic [IDX_W-1:0]  nxt_idx;
  logic [DATA_W-1:0] res_max;
  logic [IDX_W-1:0]  res_idx;
  logic              state_unused;

  // This flag records whether a group-closing beat was being held off last cycle.
  // It is kept for debug visibility only.
  assign state_unused = (state == STALL);

  max_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a       (run_max),
    .b       (in_data),
    .max_val (cmp_max),
    .sel_b   (cmp_sel_b)
  );

  // Handshake decode: only a group-closing position can be blocked by a pending result.
  always_comb begin
    at_last   = (cnt == LAST);
    out_stall = out_valid && !out_ready;
`ifdef MAX_FLUSH_EN
    close_pos = at_last || flush;
`else
    close_pos = at_last;
`endif
    in_ready  = !(close_pos && out_stall);
    beat      = in_valid && in_ready;
`ifdef MAX_FLUSH_EN
    close     = (beat && at_last) || (flush && !out_stall && (beat || (cnt != '0)));
`else
    close     = beat && at_last;
`endif
  end

  // Running max after this beat. The first beat of a group loads unconditionally.
  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    if (cnt == '0) begin
      nxt_max = in_data;
      nxt_idx = '0;
    end else if (cmp_sel_b) begin
      nxt_max = cmp_max;
      nxt_idx = cnt;
    end
    res_max = beat ? nxt_max : run_max;
    res_idx = beat ? nxt_idx : run_idx;
  end

  // Group counter, running max and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
    end else begin
      if (close) begin
        out_max   <= res_max;
        out_idx   <= res_idx;
        out_valid <= 1'b1;
        cnt       <= '0;
      end else begin
        if (beat) begin
          run_max <= nxt_max;
          run_idx <= nxt_idx;
          cnt     <= cnt + IDX_W'(1);
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // Stall tracking: stay in STALL while a closing beat waits on a held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      case (state)
        COLLECT: if (in_valid && close_pos && out_stall) state <= STALL;
        STALL:   if (out_ready) state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
